serial_shift_sequencer: RTL and testbench

Sequencer that feeds and clocks a downstream serial-in/serial-out shift chain of DEPTH stages. It accepts parallel words over a valid/ready handshake and shifts each word out LSB-first on a single serial line, asserting a per-bit shift enable for the chain. When no further word is pending, it flushes the chain with zeros so the last bit reaches the chain output, then pulses `done`. It sits between a parallel word producer and the shift-register datapath, and is the only block that drives the chain's data and enable.

---
 rtl/serial_shift_sequencer.sv | 118 +++++++++++
 tb/tb_serial_shift_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_shift_sequencer
// Purpose  : Serializes parallel words LSB-first onto a shift chain, drives
//            the chain enable, flushes DEPTH zeros after the last word and
//            pulses done when the last bit has left the chain.
// Revision : 1.0 - initial release
// ============================================================================
module serial_shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             sdo,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [FCW-1:0] FL_LAST  = FCW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nx;
    logic [FCW-1:0]   fl_cnt, fl_cnt_nx;
    logic             done_nx;
    logic             accept;
    logic             last_bit;

    assign last_bit = (state == SHIFT) && (bit_cnt == BIT_LAST);

    // rst gates in_ready so nothing is offered while the block is held in reset.
    assign in_ready = rst && ((state == IDLE) || (last_bit && !stall));
    assign accept   = in_valid && in_ready;
    assign shift_en = ((state == SHIFT) || (state == FLUSH)) && !stall;

    // sdo and busy are decoded purely from flops, so they carry no input path.
    assign sdo  = (state == SHIFT) && sreg[0];
    assign busy = (state != IDLE);

    // State and datapath registers; reset aborts any word without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            fl_cnt  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            bit_cnt <= bit_cnt_nx;
            fl_cnt  <= fl_cnt_nx;
            done    <= done_nx;
        end
    end

    // Next-state logic: load on accept, shift while not stalled, then flush.
    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        fl_cnt_nx  = fl_cnt;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nx    = in_data;
                    bit_cnt_nx = '0;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    if (bit_cnt != BIT_LAST) begin
                        sreg_nx    = sreg >> 1;
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end else if (accept) begin
                        // Reload on the last-bit edge keeps words gapless.
                        sreg_nx    = in_data;
                        bit_cnt_nx = '0;
                    end else begin
                        fl_cnt_nx = '0;
                        state_nx  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    fl_cnt_nx = fl_cnt + 1'b1;
                    if (fl_cnt == FL_LAST) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_shift_sequencer
// Purpose  : Directed self-checking bench for serial_shift_sequencer
//            (WIDTH=8, DEPTH=4) with a 4-stage chain model on the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_shift_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       stall;
    logic       sdo;
    logic       shift_en;
    logic       busy;
    logic       done;

    logic [3:0] chain;
    logic       chain_out;

    int checks = 0;
    int errors = 0;

    serial_shift_sequencer #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .stall    (stall),
        .sdo      (sdo),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Downstream 4-stage chain: captures sdo on enabled edges.
    always @(posedge clk or negedge rst) begin
        if (!rst) chain <= '0;
        else if (shift_en) chain <= {chain[2:0], sdo};
    end
    assign chain_out = chain[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follows a single unstalled word from the cycle after its accept edge.
    task automatic watch_word(input string tag, input logic [7:0] w);
        for (int k = 1; k <= 14; k++) begin
            step();
            in_valid = 1'b0;
            #3;
            if (k <= 8) begin
                chk($sformatf("%s sdo k%0d", tag, k), sdo, w[k-1]);
                chk($sformatf("%s en k%0d", tag, k), shift_en, 1);
                chk($sformatf("%s busy k%0d", tag, k), busy, 1);
            end else if (k <= 12) begin
                chk($sformatf("%s flush sdo k%0d", tag, k), sdo, 0);
                chk($sformatf("%s flush en k%0d", tag, k), shift_en, 1);
                chk($sformatf("%s flush rdy k%0d", tag, k), in_ready, 0);
            end
            if (k >= 5 && k <= 12)
                chk($sformatf("%s chain k%0d", tag, k), chain_out, w[k-5]);
            chk($sformatf("%s done k%0d", tag, k), done, (k == 13) ? 1 : 0);
            if (k == 13) begin
                chk($sformatf("%s done busy", tag), busy, 0);
                chk($sformatf("%s done rdy", tag), in_ready, 1);
            end
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] v;
        int idx;

        clk      = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 1'b0;

        // Reset state
        #12;
        chk("rst sdo", sdo, 0);
        chk("rst en", shift_en, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rdy", in_ready, 0);
        step();
        rst = 1'b1;
        #3;
        chk("release rdy", in_ready, 1);

        // Single word A5
        w = 8'hA5;
        step();
        in_valid = 1'b1;
        in_data  = w;
        #3;
        chk("t1 rdy", in_ready, 1);
        watch_word("t1", w);

        // Back-to-back FF then 00
        step();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #3;
        chk("t2 rdy", in_ready, 1);
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k == 1) in_data = 8'h00;
            if (k == 9) in_valid = 1'b0;
            #3;
            if (k <= 16) begin
                chk($sformatf("t2 sdo k%0d", k), sdo, (k <= 8) ? 1 : 0);
                chk($sformatf("t2 en k%0d", k), shift_en, 1);
                chk($sformatf("t2 rdy k%0d", k), in_ready, (k == 8 || k == 16) ? 1 : 0);
            end else if (k <= 20) begin
                chk($sformatf("t2 flush sdo k%0d", k), sdo, 0);
                chk($sformatf("t2 flush rdy k%0d", k), in_ready, 0);
            end
            chk($sformatf("t2 done k%0d", k), done, (k == 21) ? 1 : 0);
            if (k == 21) begin
                chk("t2 done busy", busy, 0);
                chk("t2 done rdy", in_ready, 1);
            end
        end

        // Stall for 3 cycles on bit 3 of 3C (stall also high in IDLE)
        w = 8'h3C;
        step();
        in_valid = 1'b1;
        in_data  = w;
        stall    = 1'b1;
        #3;
        chk("t3 rdy idle stall", in_ready, 1);
        for (int k = 1; k <= 17; k++) begin
            step();
            in_valid = 1'b0;
            stall    = (k >= 4 && k <= 6);
            #3;
            if (k <= 11) begin
                idx = (k <= 4) ? k - 1 : ((k <= 7) ? 3 : k - 4);
                chk($sformatf("t3 sdo k%0d", k), sdo, w[idx]);
                chk($sformatf("t3 en k%0d", k), shift_en, stall ? 0 : 1);
            end else if (k <= 15) begin
                chk($sformatf("t3 flush sdo k%0d", k), sdo, 0);
                chk($sformatf("t3 flush en k%0d", k), shift_en, 1);
            end
            chk($sformatf("t3 done k%0d", k), done, (k == 16) ? 1 : 0);
        end

        // Reset during bit 5 of C3, then 81
        w = 8'hC3;
        step();
        in_valid = 1'b1;
        in_data  = w;
        #3;
        for (int k = 1; k <= 6; k++) begin
            step();
            in_valid = 1'b0;
            #3;
            chk($sformatf("t4 sdo k%0d", k), sdo, w[k-1]);
        end
        rst = 1'b0;
        #1;
        chk("t4 rst sdo", sdo, 0);
        chk("t4 rst en", shift_en, 0);
        chk("t4 rst busy", busy, 0);
        chk("t4 rst done", done, 0);
        chk("t4 rst rdy", in_ready, 0);
        for (int k = 1; k <= 2; k++) begin
            step();
            #3;
            chk($sformatf("t4 held en k%0d", k), shift_en, 0);
            chk($sformatf("t4 held busy k%0d", k), busy, 0);
            chk($sformatf("t4 held done k%0d", k), done, 0);
        end
        w = 8'h81;
        step();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = w;
        #3;
        chk("t4 release rdy", in_ready, 1);
        chk("t4 release done", done, 0);
        watch_word("t4", w);

        // 55 offered throughout FLUSH of 0F, taken in the done cycle
        w = 8'h0F;
        v = 8'h55;
        step();
        in_valid = 1'b1;
        in_data  = w;
        #3;
        for (int k = 1; k <= 26; k++) begin
            step();
            in_valid = (k >= 9 && k <= 13);
            in_data  = v;
            #3;
            if (k <= 8) begin
                chk($sformatf("t5 sdo k%0d", k), sdo, w[k-1]);
            end else if (k <= 12) begin
                chk($sformatf("t5 flush rdy k%0d", k), in_ready, 0);
                chk($sformatf("t5 flush busy k%0d", k), busy, 1);
                chk($sformatf("t5 flush sdo k%0d", k), sdo, 0);
            end else if (k == 13) begin
                chk("t5 done rdy", in_ready, 1);
                chk("t5 done busy", busy, 0);
            end else if (k <= 21) begin
                chk($sformatf("t5 w2 sdo k%0d", k), sdo, v[k-14]);
                chk($sformatf("t5 w2 en k%0d", k), shift_en, 1);
                chk($sformatf("t5 w2 busy k%0d", k), busy, 1);
            end else if (k <= 25) begin
                chk($sformatf("t5 w2 flush sdo k%0d", k), sdo, 0);
            end
            chk($sformatf("t5 done k%0d", k), done, (k == 13 || k == 26) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
